// File: rtl/controller_fifo_packer.sv
// controller_fifo_packer
//   Word-in / packet-out FIFO. Single words of dbits are written one at a
//   time; a read removes rd_pkt words at once and presents them as one
//   registered packet on dout, oldest word in the least-significant slot.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   wr, din      write request and write word
//   rd           packet read request
//   dout         registered read packet (dbits*rd_pkt), holds between reads
//   dout_valid   one-cycle pulse after an accepted read
//   count        words stored (abits+1 bits)
//   empty, full, almost_full, rd_ready   decoded from the registered count
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was rejected (fewer than rd_pkt words)

module controller_fifo_packer #(
    parameter int abits    = 3,
    parameter int dbits    = 2,
    parameter int rd_pkt   = 2,
    parameter int af_level = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [dbits-1:0]        din,
    output logic [dbits*rd_pkt-1:0] dout,
    output logic                    dout_valid,
    output logic [abits:0]          count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    rd_ready,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2**abits;

    localparam logic [abits:0]   DEPTH_C = (abits+1)'(DEPTH);
    localparam logic [abits:0]   PKT_C   = (abits+1)'(rd_pkt);
    localparam logic [abits:0]   AF_C    = (abits+1)'(af_level);
    localparam logic [abits:0]   ONE_C   = (abits+1)'(1);
    // rd_pkt == DEPTH truncates to 0, which is the correct modulo advance.
    localparam logic [abits-1:0] PKT_P   = abits'(rd_pkt);
    localparam logic [abits-1:0] ONE_P   = abits'(1);

    logic [dbits-1:0]        mem [DEPTH];
    logic [abits-1:0]        wr_ptr;
    logic [abits-1:0]        rd_ptr;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [abits:0]          count_next;
    logic [dbits*rd_pkt-1:0] rd_pkt_data;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);
    assign rd_ready    = (count >= PKT_C);

    // A read frees space in the same cycle, so a write into a full FIFO is
    // still accepted when a packet read is accepted alongside it.
    assign rd_acc = rd && rd_ready;
    assign wr_acc = wr && (!full || rd_acc);

    always_comb begin
        count_next = count + (wr_acc ? ONE_C : '0) - (rd_acc ? PKT_C : '0);
    end

    // Gather the rd_pkt oldest words; the pointer sum wraps modulo DEPTH.
    always_comb begin
        rd_pkt_data = '0;
        for (int i = 0; i < rd_pkt; i++) begin
            rd_pkt_data[i*dbits +: dbits] = mem[rd_ptr + abits'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PKT_P;
                dout   <= rd_pkt_data;
            end
            dout_valid <= rd_acc;
            count      <= count_next;
            if (wr && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the write is gated by reset so that unknown
    // wr/din during reset cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule
